// File: rtl/riscv_top.sv
// riscv_top: single-cycle RV32I-subset core (ADD/SUB/AND/OR/SLT, ADDI/ANDI/ORI,
// LW/SW, BEQ/BNE) with a 64-word instruction ROM, a 32x32 register file and a
// 64-word data RAM. Synchronous active-high reset clears PC and registers only.

module Instruction_Memory (
    input  logic [5:0]  idx,
    output logic [31:0] instr
);
    // Built-in program; everything past the halt loop is NOP
    always_comb begin
        case (idx)
            6'd0:    instr = 32'h0050_0413; // addi x8,x0,5
            6'd1:    instr = 32'h0030_0493; // addi x9,x0,3
            6'd2:    instr = 32'h0094_0533; // add  x10,x8,x9
            6'd3:    instr = 32'h02A0_2C23; // sw   x10,56(x0)
            6'd4:    instr = 32'h0380_2583; // lw   x11,56(x0)
            6'd5:    instr = 32'h4085_8633; // sub  x12,x11,x8
            6'd6:    instr = 32'h0000_0063; // beq  x0,x0,0
            default: instr = 32'h0000_0013;
        endcase
    end
endmodule

module Control_Unit (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic       Branch,
    output logic       BranchNe,
    output logic [1:0] ImmSel,
    output logic [2:0] ALUControl
);
    localparam logic [1:0] IMM_I = 2'd0, IMM_S = 2'd1, IMM_B = 2'd2;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                           ALU_OR = 3'd3, ALU_SLT = 3'd4;

    // Decode; anything unrecognised falls through as a NOP (no side effects)
    always_comb begin
        RegWrite   = 1'b0;
        ALUSrc     = 1'b0;
        MemWrite   = 1'b0;
        MemToReg   = 1'b0;
        Branch     = 1'b0;
        BranchNe   = 1'b0;
        ImmSel     = IMM_I;
        ALUControl = ALU_ADD;
        case (opcode)
            7'b0110011: begin
                RegWrite = 1'b1;
                case (funct3)
                    3'b000:  ALUControl = funct7b5 ? ALU_SUB : ALU_ADD;
                    3'b111:  ALUControl = ALU_AND;
                    3'b110:  ALUControl = ALU_OR;
                    3'b010:  ALUControl = ALU_SLT;
                    default: RegWrite = 1'b0;
                endcase
            end
            7'b0010011: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
                case (funct3)
                    3'b000:  ALUControl = ALU_ADD;
                    3'b111:  ALUControl = ALU_AND;
                    3'b110:  ALUControl = ALU_OR;
                    default: RegWrite = 1'b0;
                endcase
            end
            7'b0000011: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            7'b0100011: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
                ImmSel   = IMM_S;
            end
            7'b1100011: begin
                ImmSel     = IMM_B;
                ALUControl = ALU_SUB;
                Branch     = (funct3 == 3'b000);
                BranchNe   = (funct3 == 3'b001);
            end
            default: ;
        endcase
    end
endmodule

module Register_File (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] Registers [0:31];

    // Reads see the pre-edge value; x0 is hard-wired to zero
    assign rd1 = (rs1 == 5'd0) ? 32'd0 : Registers[rs1];
    assign rd2 = (rs2 == 5'd0) ? 32'd0 : Registers[rs2];

    // Reset clears every register; writes to x0 are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) Registers[i] <= 32'd0;
        end else if (we && rd != 5'd0) begin
            Registers[rd] <= wd;
        end
    end
endmodule

module Data_Memory (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [5:0]  idx,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    // Power-up contents are zero; reset does not touch the RAM
    logic [31:0] D_Memory [0:63] = '{default: 32'd0};

    assign rd = D_Memory[idx];

    // Store commits on the edge unless reset wins that edge
    always_ff @(posedge clk) begin
        if (we && !reset) D_Memory[idx] <= wd;
    end
endmodule

module riscv_top (
    input logic clk,
    input logic reset
);
    logic [31:0] PC_top, instruction_Top, Rd1_top, Rd2_top, ImmExt_top;
    logic [31:0] address_top, WriteBack_top, mem_rdata, alu_b, pc_next;
    logic        MemWrite_top, reg_write, alu_src, mem_to_reg, branch, branch_ne;
    logic [1:0]  imm_sel;
    logic [2:0]  alu_ctrl;
    logic        taken;
    logic        unused_bits;

    assign unused_bits = ^{PC_top[31:8], PC_top[1:0], address_top[31:8], address_top[1:0]};

    Instruction_Memory Instruction_Memory (.idx(PC_top[7:2]), .instr(instruction_Top));

    Control_Unit Control_Unit (
        .opcode(instruction_Top[6:0]), .funct3(instruction_Top[14:12]),
        .funct7b5(instruction_Top[30]), .RegWrite(reg_write), .ALUSrc(alu_src),
        .MemWrite(MemWrite_top), .MemToReg(mem_to_reg), .Branch(branch),
        .BranchNe(branch_ne), .ImmSel(imm_sel), .ALUControl(alu_ctrl)
    );

    Register_File Register_File (
        .clk(clk), .reset(reset), .we(reg_write),
        .rs1(instruction_Top[19:15]), .rs2(instruction_Top[24:20]),
        .rd(instruction_Top[11:7]), .wd(WriteBack_top),
        .rd1(Rd1_top), .rd2(Rd2_top)
    );

    // Immediate formats: I, S (split field), B (halfword offset)
    always_comb begin
        case (imm_sel)
            2'd1:    ImmExt_top = {{20{instruction_Top[31]}}, instruction_Top[31:25],
                                   instruction_Top[11:7]};
            2'd2:    ImmExt_top = {{20{instruction_Top[31]}}, instruction_Top[7],
                                   instruction_Top[30:25], instruction_Top[11:8], 1'b0};
            default: ImmExt_top = {{20{instruction_Top[31]}}, instruction_Top[31:20]};
        endcase
    end

    assign alu_b = alu_src ? ImmExt_top : Rd2_top;

    // ALU: wrap-around arithmetic, signed set-less-than
    always_comb begin
        case (alu_ctrl)
            3'd1:    address_top = Rd1_top - alu_b;
            3'd2:    address_top = Rd1_top & alu_b;
            3'd3:    address_top = Rd1_top | alu_b;
            3'd4:    address_top = {31'd0, $signed(Rd1_top) < $signed(alu_b)};
            default: address_top = Rd1_top + alu_b;
        endcase
    end

    Data_Memory Data_Memory (
        .clk(clk), .reset(reset), .we(MemWrite_top), .idx(address_top[7:2]),
        .wd(Rd2_top), .rd(mem_rdata)
    );

    assign WriteBack_top = mem_to_reg ? mem_rdata : address_top;

    assign taken   = (branch && Rd1_top == Rd2_top) || (branch_ne && Rd1_top != Rd2_top);
    assign pc_next = taken ? PC_top + ImmExt_top : PC_top + 32'd4;

    // PC advances every cycle; reset overrides any branch
    always_ff @(posedge clk) begin
        if (reset) PC_top <= 32'd0;
        else       PC_top <= pc_next;
    end
endmodule

// File: tb/tb_riscv_top.sv
// tb_riscv_top: randomized reset schedule; an instruction-level model of the
// default program predicts per-cycle decode/ALU values and post-edge state,
// queued for a monitor that compares against hierarchical probes.
module tb_riscv_top;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    bit active = 1'b1;

    riscv_top dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    typedef struct {
        bit               chk_comb;
        bit               chk_alu;
        bit               chk_imm;
        bit [31:0]        ins;
        bit               alusrc;
        bit [31:0]        imm;
        bit [31:0]        addr;
        bit [31:0]        wb;
        bit               memwr;
        bit [31:0]        pc;
        bit [31:0][31:0]  regs;
        bit [63:0][31:0]  mem;
    } exp_t;

    exp_t sb[$];

    bit [31:0] m_rom [64];
    bit [31:0] m_regs [32];
    bit [31:0] m_mem [64];
    bit [31:0] m_pc;
    bit        m_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: execute one instruction at the ISA level for the coming edge
    task automatic step(input bit r);
        exp_t e;
        bit [31:0] ins, a, b, imm, res, nxt;
        bit [6:0] op;
        bit [2:0] f3;
        bit [4:0] rd;
        bit wr, taken;
        ins = m_rom[m_pc[7:2]];
        op = ins[6:0]; f3 = ins[14:12]; rd = ins[11:7];
        a = m_regs[ins[19:15]]; b = m_regs[ins[24:20]];
        e.chk_comb = m_known; e.chk_alu = 1'b0; e.chk_imm = 1'b0;
        e.ins = ins; e.alusrc = 1'b0; e.memwr = 1'b0; e.imm = 0;
        res = 0; wr = 1'b0; taken = 1'b0;
        case (op)
            7'h33: begin
                wr = 1'b1; e.chk_alu = 1'b1;
                if (f3 == 0) res = ins[30] ? a - b : a + b;
                else if (f3 == 7) res = a & b;
                else if (f3 == 6) res = a | b;
                else if (f3 == 2) res = ($signed(a) < $signed(b)) ? 1 : 0;
                else begin wr = 1'b0; e.chk_alu = 1'b0; end
            end
            7'h13: begin
                e.alusrc = 1'b1; e.chk_imm = 1'b1; imm = 32'($signed(ins[31:20]));
                wr = 1'b1; e.chk_alu = 1'b1;
                if (f3 == 0) res = a + imm;
                else if (f3 == 7) res = a & imm;
                else if (f3 == 6) res = a | imm;
                else begin wr = 1'b0; e.chk_alu = 1'b0; end
            end
            7'h03: begin
                e.alusrc = 1'b1; e.chk_imm = 1'b1; imm = 32'($signed(ins[31:20]));
                res = a + imm; wr = 1'b1; e.chk_alu = 1'b1;
            end
            7'h23: begin
                e.alusrc = 1'b1; e.chk_imm = 1'b1; e.memwr = 1'b1; e.chk_alu = 1'b1;
                imm = 32'($signed({ins[31:25], ins[11:7]}));
                res = a + imm;
            end
            7'h63: begin
                e.chk_imm = 1'b1;
                imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                taken = (f3 == 0 && a == b) || (f3 == 1 && a != b);
            end
            default: ;
        endcase
        e.imm = imm;
        e.addr = res;
        e.wb = (op == 7'h03) ? m_mem[res[7:2]] : res;
        nxt = taken ? m_pc + imm : m_pc + 4;
        if (r) begin
            m_pc = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (wr && rd != 0) m_regs[rd] = e.wb;
            if (op == 7'h23) m_mem[res[7:2]] = b;
            m_pc = nxt;
        end
        e.pc = m_pc;
        for (int i = 0; i < 32; i++) e.regs[i] = m_regs[i];
        for (int i = 0; i < 64; i++) e.mem[i] = m_mem[i];
        sb.push_back(e);
    endtask

    // Stimulus: random reset bursts over a few hundred cycles
    initial begin
        int hold;
        bit r;
        int rst0;
        for (int i = 0; i < 64; i++) begin m_rom[i] = 32'h13; m_mem[i] = 0; end
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_rom[0] = 32'h00500413; m_rom[1] = 32'h00300493; m_rom[2] = 32'h00940533;
        m_rom[3] = 32'h02A02C23; m_rom[4] = 32'h03802583; m_rom[5] = 32'h40858633;
        m_rom[6] = 32'h00000063;
        reset = 1'b1;
        hold = 0;
        rst0 = 1 + $urandom_range(0, 2);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (n < rst0 || n == 40) r = 1'b1;
            else if (hold > 0) begin r = 1'b1; hold--; end
            else if ($urandom_range(0, 24) == 0) begin r = 1'b1; hold = $urandom_range(0, 1); end
            else r = 1'b0;
            reset = r;
            step(r);
        end
        @(posedge clk);
        #3;
        active = 1'b0;
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: compare combinational view mid-cycle, then state after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!active) break;
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard: empty queue got 0 expected 1 at %0t", $time);
                continue;
            end
            e = sb.pop_front();
            if (e.chk_comb) begin
                chk("instruction", dut.instruction_Top, e.ins);
                chk("alusrc", {31'd0, dut.Control_Unit.ALUSrc}, {31'd0, e.alusrc});
                chk("memwrite", {31'd0, dut.MemWrite_top}, {31'd0, e.memwr});
                if (e.chk_imm) chk("immext", dut.ImmExt_top, e.imm);
                if (e.chk_alu) begin
                    chk("address", dut.address_top, e.addr);
                    chk("writeback", dut.WriteBack_top, e.wb);
                end
            end
            @(posedge clk);
            #1;
            chk("pc", dut.PC_top, e.pc);
            begin
                int bad = -1;
                for (int i = 0; i < 32; i++)
                    if (bad < 0 && dut.Register_File.Registers[i] !== e.regs[i]) bad = i;
                checks++;
                if (bad >= 0) begin
                    failures++;
                    $display("FAIL regs: x%0d got %h expected %h at %0t", bad,
                             dut.Register_File.Registers[bad], e.regs[bad], $time);
                end
                bad = -1;
                for (int i = 0; i < 64; i++)
                    if (bad < 0 && dut.Data_Memory.D_Memory[i] !== e.mem[i]) bad = i;
                checks++;
                if (bad >= 0) begin
                    failures++;
                    $display("FAIL dmem: word %0d got %h expected %h at %0t", bad,
                             dut.Data_Memory.D_Memory[bad], e.mem[bad], $time);
                end
            end
        end
    end
endmodule
